// File: rtl/action_table_ctrl.sv
// Action table port sequencer: zeroing sweep after reset / clear, lookup-priority
// arbitration with a starvation guard for config writes, and a 2-stage lookup
// pipeline that decodes the BRAM word into registered action results.
module action_table_ctrl #(
   parameter int DEPTH        = 1024,
   parameter int AW           = 10,
   parameter int STARVE_LIMIT = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          lk_valid,
   input  logic [AW-1:0] lk_flow_id,
   output logic          lk_ready,
   input  logic          wr_valid,
   input  logic [AW-1:0] wr_addr,
   input  logic [31:0]   wr_data,
   output logic          wr_ready,
   output logic          wr_done,
   input  logic          clear_req,
   output logic          busy,
   output logic          act_valid,
   output logic          act_hit,
   output logic          act_drop,
   output logic          act_forward,
   output logic          act_modify,
   output logic          act_trap,
   output logic          act_count,
   output logic [3:0]    act_out_port,
   output logic [AW-1:0] act_flow_id,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [19:0]   mem_wdata,
   input  logic [19:0]   mem_rdata
);

   typedef enum logic [1:0] {S_INIT, S_RUN, S_CLEAR} state_t;
   localparam int SCW = $clog2(STARVE_LIMIT + 1);

   state_t          state, state_nxt;
   logic [AW-1:0]   ptr;
   logic            sweep_last;
   logic [SCW-1:0]  starve_cnt;
   logic            forced, lk_gnt, wr_gnt;
   logic [1:0]      vld_pipe;
   logic [AW-1:0]   fid_s1;
   logic            hit_s1;
   logic [19:0]     wr_word;
   logic            unused_wr_bits;

   assign sweep_last     = (ptr == AW'(DEPTH - 1));
   assign unused_wr_bits = ^wr_data[31:9];
   assign wr_word        = {wr_data[0], wr_data[1], wr_data[2], wr_data[6:3],
                            wr_data[7], wr_data[8], 1'b1, 10'(wr_addr)};

   // State register and sweep pointer; pointer parks at 0 outside a sweep
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_INIT;
         ptr   <= '0;
      end else begin
         state <= state_nxt;
         if (state != S_RUN && !sweep_last) ptr <= ptr + 1'b1;
         else                               ptr <= '0;
      end
   end

   // Next state, handshakes and the memory port mux (one grant per cycle)
   always_comb begin
      state_nxt = state;
      busy      = 1'b1;
      forced    = 1'b0;
      lk_ready  = 1'b0;
      wr_ready  = 1'b0;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      case (state)
         S_INIT, S_CLEAR: begin
            if (sweep_last) state_nxt = S_RUN;
            // held in reset the port stays quiet even though state reads INIT
            mem_en   = rst_n;
            mem_we   = rst_n;
            mem_addr = ptr;
         end
         S_RUN: begin
            busy     = 1'b0;
            forced   = wr_valid && (starve_cnt == SCW'(STARVE_LIMIT));
            lk_ready = !forced;
            wr_ready = !lk_valid || forced;
            if (clear_req) state_nxt = S_CLEAR;
         end
         default: state_nxt = S_INIT;
      endcase
      lk_gnt = lk_valid && lk_ready;
      wr_gnt = wr_valid && wr_ready && !lk_gnt;
      if (lk_gnt) begin
         mem_en   = 1'b1;
         mem_addr = lk_flow_id;
      end else if (wr_gnt) begin
         mem_en    = 1'b1;
         mem_we    = 1'b1;
         mem_addr  = wr_addr;
         mem_wdata = wr_word;
      end
   end

   // Count lookup grants that overtook a waiting write
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                   starve_cnt <= '0;
      else if (wr_gnt || !wr_valid) starve_cnt <= '0;
      else if (lk_gnt)              starve_cnt <= starve_cnt + 1'b1;
   end

   // Write completion strobe, one cycle after the grant
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) wr_done <= 1'b0;
      else        wr_done <= wr_gnt;
   end

   // Lookup valid shift and flow_id tag riding alongside the BRAM read
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_pipe <= '0;
         fid_s1   <= '0;
      end else begin
         vld_pipe <= {vld_pipe[0], lk_gnt};
         if (lk_gnt) fid_s1 <= lk_flow_id;
      end
   end

   assign hit_s1    = vld_pipe[0] && mem_rdata[10] && (mem_rdata[9:0] == 10'(fid_s1));
   assign act_valid = vld_pipe[1];

   // Registered decode; fields are zero on a miss or when no result is due
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         act_hit      <= 1'b0;
         act_drop     <= 1'b0;
         act_forward  <= 1'b0;
         act_modify   <= 1'b0;
         act_out_port <= '0;
         act_trap     <= 1'b0;
         act_count    <= 1'b0;
         act_flow_id  <= '0;
      end else begin
         act_hit      <= hit_s1;
         act_drop     <= hit_s1 & mem_rdata[19];
         act_forward  <= hit_s1 & mem_rdata[18];
         act_modify   <= hit_s1 & mem_rdata[17];
         act_out_port <= hit_s1 ? mem_rdata[16:13] : 4'd0;
         act_trap     <= hit_s1 & mem_rdata[12];
         act_count    <= hit_s1 & mem_rdata[11];
         act_flow_id  <= vld_pipe[0] ? fid_s1 : '0;
      end
   end

endmodule
